// File: rtl/activation.sv
// Two-stage streaming activation (ReLU or hard sigmoid) with stb/rdy handshakes.
// Define ACTIVATION_DERIVATIVE_EN to also emit the registered derivative on m_d_dat.
module activation #(
  parameter int W = 16,
  parameter int Q = 8,
  parameter int F = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_x_stb,
  input  logic [W-1:0] s_x_dat,
  output logic         s_x_rdy,
  output logic         m_y_stb,
  output logic [W-1:0] m_y_dat,
  input  logic         m_y_rdy
`ifdef ACTIVATION_DERIVATIVE_EN
  ,
  output logic [W-1:0] m_d_dat
`endif
);

  // Constants carried in W+2 bits so the shifted sum and the +/-2*ONE bounds never wrap
  localparam logic signed [W+1:0] ONE_X  = (W+2)'(1 << Q);
  localparam logic signed [W+1:0] HALF_X = ONE_X >>> 1;
  localparam logic signed [W+1:0] QTR_X  = ONE_X >>> 2;
  localparam logic signed [W+1:0] TWO_X  = ONE_X <<< 1;

  logic                en;
  logic                vld_p1;
  logic signed [W-1:0] x_p1;
  logic                vld_p2;
  logic signed [W-1:0] y_p2;

  function automatic logic signed [W-1:0] sat_fn(input logic signed [W+1:0] s);
    if (s < 0) return '0;
    if (s > ONE_X) return ONE_X[W-1:0];
    return s[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] act_fn(input logic signed [W-1:0] x);
    logic signed [W+1:0] xe;
    xe = {{2{x[W-1]}}, x};
    if (F == 1) return sat_fn((xe >>> 2) + HALF_X);
    return (x > 0) ? x : '0;
  endfunction

  assign en      = !vld_p2 || m_y_rdy;
  assign s_x_rdy = en;
  assign m_y_stb = vld_p2;
  assign m_y_dat = y_p2;

  // Stage p1: capture x
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else if (en) vld_p1 <= s_x_stb;
  end

  always_ff @(posedge clk) begin
    if (en && s_x_stb) x_p1 <= s_x_dat;
  end

  // Stage p2: registered result; data only loads on a real token so it stays 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      y_p2   <= '0;
    end else if (en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) y_p2 <= act_fn(x_p1);
    end
  end

`ifdef ACTIVATION_DERIVATIVE_EN
  logic signed [W-1:0] d_p2;

  function automatic logic signed [W-1:0] deriv_fn(input logic signed [W-1:0] x);
    logic signed [W+1:0] xe;
    xe = {{2{x[W-1]}}, x};
    if (F == 1) return (xe > -TWO_X && xe < TWO_X) ? QTR_X[W-1:0] : '0;
    return (x > 0) ? ONE_X[W-1:0] : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) d_p2 <= '0;
    else if (en && vld_p1) d_p2 <= deriv_fn(x_p1);
  end

  assign m_d_dat = d_p2;
`endif

endmodule
